// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath width, legality helper,
// and the response-slot state encoding.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 64;

  typedef enum logic [2:0] {
    ALU_SUB = 3'b000,
    ALU_AND = 3'b001,
    ALU_OR  = 3'b011,
    ALU_ADD = 3'b111
  } aluOp_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // True for the four implemented opcodes; everything else is flagged illegal.
  function automatic logic isLegalOp(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) || (op == ALU_OR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 64-bit ALU: add/sub wrap, AND, OR; illegal opcodes give 0.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [2:0]            opcode,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zeroFlag,
  output logic                  illegalOp
);

  // Opcode decode and datapath; zero flag derived from the same result
  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD: result = operand1 + operand2;
      ALU_SUB: result = operand1 - operand2;
      ALU_AND: result = operand1 & operand2;
      ALU_OR:  result = operand1 | operand2;
      default: result = '0;
    endcase
    zeroFlag  = (result == '0);
    illegalOp = !isLegalOp(opcode);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Search starts one past lastGrant and
// wraps; grant is one-hot, or zero when disabled or nothing is requesting.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [IDW-1:0]     lastGrant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grantIdx
);

  int   idx;
  logic found;

  // Rotating priority search from lastGrant+1, first hit wins
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = 0;
    if (enable) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(lastGrant) + k) % NUM_REQ;
        if (!found && req[idx]) begin
          found       = 1'b1;
          grant[idx]  = 1'b1;
          grantIdx    = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters. A round-robin grant feeds the
// ALU each accepting cycle; the result lands in a single registered response
// slot that may drain and refill on the same edge.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int NUM_REQ    = 2,
  parameter int TAG_WIDTH  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [NUM_REQ-1:0]                   reqValid_in,
  output logic [NUM_REQ-1:0]                   reqReady_out,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   reqOperand1_in,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   reqOperand2_in,
  input  logic [NUM_REQ-1:0][2:0]              reqOpcode_in,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]    reqTag_in,
  output logic                                 respValid_out,
  input  logic                                 respReady_in,
  output logic [DATA_WIDTH-1:0]                respResult_out,
  output logic                                 respZeroFlag_out,
  output logic                                 respIllegalOp_out,
  output logic [ID_WIDTH-1:0]                  respId_out,
  output logic [TAG_WIDTH-1:0]                 respTag_out
);

  slot_state_t           state_q, state_d;
  logic [ID_WIDTH-1:0]   last_grant;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  can_accept;
  logic                  handshake;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  alu_illegal;

  // Slot accepts when empty or when the held response is leaving this cycle;
  // reset masks all grants.
  assign can_accept   = (state_q == SLOT_EMPTY) || respReady_in;
  assign reqReady_out = grant;
  assign handshake    = |(grant & reqValid_in);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (reqValid_in),
    .enable    (can_accept && !rst_in),
    .lastGrant (last_grant),
    .grant     (grant),
    .grantIdx  (grant_idx)
  );

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .operand1  (reqOperand1_in[grant_idx]),
    .operand2  (reqOperand2_in[grant_idx]),
    .opcode    (reqOpcode_in[grant_idx]),
    .result    (alu_result),
    .zeroFlag  (alu_zero),
    .illegalOp (alu_illegal)
  );

  // Slot next state: a new grant always fills; otherwise a consumed slot empties
  always_comb begin
    state_d = state_q;
    if (handshake)
      state_d = SLOT_FULL;
    else if ((state_q == SLOT_FULL) && respReady_in)
      state_d = SLOT_EMPTY;
  end

  // Slot state, response payload and round-robin pointer
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q           <= SLOT_EMPTY;
      respResult_out    <= '0;
      respZeroFlag_out  <= 1'b0;
      respIllegalOp_out <= 1'b0;
      respId_out        <= '0;
      respTag_out       <= '0;
      last_grant        <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (handshake) begin
        respResult_out    <= alu_result;
        respZeroFlag_out  <= alu_zero;
        respIllegalOp_out <= alu_illegal;
        respId_out        <= grant_idx;
        respTag_out       <= reqTag_in[grant_idx];
        last_grant        <= grant_idx;
      end
    end
  end

  assign respValid_out = (state_q == SLOT_FULL);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with hand-computed expectations.
module tb_alu_share_arbiter;

  localparam int DW = 64;
  localparam int NR = 2;
  localparam int TW = 4;
  localparam int IW = 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NR-1:0]             req_valid;
  logic [NR-1:0]             req_ready;
  logic [NR-1:0][DW-1:0]     op1, op2;
  logic [NR-1:0][2:0]        opc;
  logic [NR-1:0][TW-1:0]     tag;
  logic                      resp_valid, resp_ready;
  logic [DW-1:0]             resp_result;
  logic                      resp_zero, resp_illegal;
  logic [IW-1:0]             resp_id;
  logic [TW-1:0]             resp_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TAG_WIDTH(TW), .ID_WIDTH(IW)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .reqValid_in       (req_valid),
    .reqReady_out      (req_ready),
    .reqOperand1_in    (op1),
    .reqOperand2_in    (op2),
    .reqOpcode_in      (opc),
    .reqTag_in         (tag),
    .respValid_out     (resp_valid),
    .respReady_in      (resp_ready),
    .respResult_out    (resp_result),
    .respZeroFlag_out  (resp_zero),
    .respIllegalOp_out (resp_illegal),
    .respId_out        (resp_id),
    .respTag_out       (resp_tag)
  );

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] o,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
    req_valid[i] = v;
    opc[i] = o;
    op1[i] = a;
    op2[i] = b;
    tag[i] = t;
  endtask

  task automatic chk_resp(input string name, input logic v, input logic [DW-1:0] r,
                          input logic z, input logic il, input logic [IW-1:0] id, input logic [TW-1:0] t);
    chk({name, ".valid"},   DW'(resp_valid),   DW'(v));
    chk({name, ".result"},  resp_result,       r);
    chk({name, ".zero"},    DW'(resp_zero),    DW'(z));
    chk({name, ".illegal"}, DW'(resp_illegal), DW'(il));
    chk({name, ".id"},      DW'(resp_id),      DW'(id));
    chk({name, ".tag"},     DW'(resp_tag),     DW'(t));
  endtask

  initial begin
    rst = 1'b1;
    resp_ready = 1'b1;
    req_valid = '0; op1 = '0; op2 = '0; opc = '0; tag = '0;
    tick();
    // requests during reset must not be accepted
    set_req(0, 1'b1, 3'b111, 64'd1, 64'd1, 4'd1);
    #1 chk("rst_ready", DW'(req_ready), 64'd0);
    tick();
    chk_resp("rst", 1'b0, 64'd0, 1'b0, 1'b0, 1'd0, 4'd0);

    // add 5+7 from req0
    rst = 1'b0;
    set_req(0, 1'b1, 3'b111, 64'd5, 64'd7, 4'd3);
    #1 chk("add_ready", DW'(req_ready), 64'b01);
    tick();
    req_valid[0] = 1'b0;
    chk_resp("add", 1'b1, 64'd12, 1'b0, 1'b0, 1'd0, 4'd3);

    // illegal opcode 010 from req1
    set_req(1, 1'b1, 3'b010, 64'd9, 64'd9, 4'd5);
    #1 chk("ill_ready", DW'(req_ready), 64'b10);
    tick();
    req_valid[1] = 1'b0;
    chk_resp("ill", 1'b1, 64'd0, 1'b1, 1'b1, 1'd1, 4'd5);

    // both valid: grants alternate 0,1,0,1 with one result per cycle
    set_req(0, 1'b1, 3'b000, 64'd10, 64'd4, 4'd1);
    set_req(1, 1'b1, 3'b001, 64'hF0, 64'h3C, 4'd2);
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("alt%0d_ready", k), DW'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
      tick();
      if (k % 2 == 0) chk_resp($sformatf("alt%0d", k), 1'b1, 64'd6,  1'b0, 1'b0, 1'd0, 4'd1);
      else            chk_resp($sformatf("alt%0d", k), 1'b1, 64'h30, 1'b0, 1'b0, 1'd1, 4'd2);
    end

    // req1 sub 3-3, then stall three cycles with req0 waiting
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 3'b000, 64'd3, 64'd3, 4'd7);
    #1 chk("stl_ready1", DW'(req_ready), 64'b10);
    tick();
    req_valid[1] = 1'b0;
    resp_ready = 1'b0;
    set_req(0, 1'b1, 3'b111, 64'd1, 64'd2, 4'd4);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stl%0d_ready", k), DW'(req_ready), 64'b00);
      chk_resp($sformatf("stl%0d", k), 1'b1, 64'd0, 1'b1, 1'b0, 1'd1, 4'd7);
      tick();
    end
    resp_ready = 1'b1;
    #1 chk("stl_rel_ready", DW'(req_ready), 64'b01);
    tick();
    req_valid[0] = 1'b0;
    chk_resp("stl_rel", 1'b1, 64'd3, 1'b0, 1'b0, 1'd0, 4'd4);

    // wrap-around add and OR of zeros
    set_req(0, 1'b1, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd1);
    tick();
    chk_resp("wrap", 1'b1, 64'd0, 1'b1, 1'b0, 1'd0, 4'd1);
    set_req(0, 1'b1, 3'b011, 64'd0, 64'd0, 4'd2);
    tick();
    req_valid[0] = 1'b0;
    chk_resp("or0", 1'b1, 64'd0, 1'b1, 1'b0, 1'd0, 4'd2);

    // drain with nothing pending
    tick();
    chk("drain_valid", DW'(resp_valid), 64'd0);

    // hold a response from req0, then pulse reset
    resp_ready = 1'b0;
    set_req(0, 1'b1, 3'b111, 64'd2, 64'd2, 4'd9);
    tick();
    req_valid[0] = 1'b0;
    tick();
    chk_resp("hold", 1'b1, 64'd4, 1'b0, 1'b0, 1'd0, 4'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_resp("prst", 1'b0, 64'd0, 1'b0, 1'b0, 1'd0, 4'd0);

    // priority pointer restored: req0 wins even though it was granted last
    resp_ready = 1'b1;
    set_req(0, 1'b1, 3'b001, 64'hFF, 64'h0F, 4'd6);
    set_req(1, 1'b1, 3'b111, 64'd1, 64'd1, 4'd8);
    #1 chk("prst_ready", DW'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    chk_resp("prst_first", 1'b1, 64'h0F, 1'b0, 1'b0, 1'd0, 4'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
